clint_lite: RTL and testbench
=============================

CLINT_LITE -- requirements
Module: clint_lite

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0200_0000, base of the 64 KiB register window.
REQ-002 Parameter PRESCALE, default 1, CLK cycles per mtime increment; legal range 1..65535.
REQ-003 CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-high (1 = reset asserted).
REQ-005 addr  in  32  generic-bus slave byte address.
REQ-006 wdata  in  32  write data.
REQ-007 ren  in  1  read request.
REQ-008 wen  in  1  write request.
REQ-009 byte_en  in  4  write byte lanes; bit i selects wdata[8i+7:8i].
REQ-010 rdata  out  32  read data; valid only in the cycle busy=0.
REQ-011 busy  out  1  generic-bus wait; 0 for exactly one cycle per accepted request.
REQ-012 timer_int  out  1  machine timer interrupt to core_interrupt_if.
REQ-013 soft_int  out  1  machine software interrupt to core_interrupt_if.

Function
REQ-014 Register map (offset from BASE_ADDR):
- 0x0000 msip: bit0 only; bits 31:1 read 0.
- 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
- 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
REQ-015 Any other address inside or outside the window: reads return 0, writes are ignored, handshake unchanged.
REQ-016 Bus FSM has two states, IDLE and ACK; busy=1 in IDLE, busy=0 in ACK.
REQ-017 In IDLE, ren|wen high: latch addr, wdata, byte_en and op, go to ACK next cycle; otherwise stay in IDLE.
REQ-018 ACK always returns to IDLE next cycle; requests present during ACK are not accepted until the following IDLE cycle (2-cycle minimum per transfer).
REQ-019 ren and wen both high: treated as write; rdata = 0.
REQ-020 Reads: rdata registered on entry to ACK; returns the register value as of the acceptance cycle.
REQ-021 Writes: take effect at the clock edge ending the ACK cycle; only lanes with byte_en set are modified.
REQ-022 Prescaler: 16-bit counter; counts 0..PRESCALE-1 then wraps to 0; a tick is asserted in the wrap cycle.
REQ-023 PRESCALE = 1: a tick occurs every cycle.
REQ-024 On each tick mtime += 1, 64-bit, wrapping from 2^64-1 to 0.
REQ-025 A write to mtime in the same cycle as a tick: the written lanes take the write data, the unwritten lanes keep the pre-increment value, and no increment is applied that cycle.
REQ-026 A write to mtime does not reset the prescaler.
REQ-027 timer_int is registered: it equals (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on the current-cycle register values, so it is visible one cycle after the values change.
REQ-028 soft_int = msip bit0, driven directly from the register.
REQ-029 Reads of mtime halves are independent, with no snapshot; software uses the hi/lo/hi retry sequence.

Reset
REQ-030 On nRST=1, asynchronously:
- mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, prescaler = 0.
- FSM = IDLE, rdata = 0, busy = 1, timer_int = 0, soft_int = 0.
REQ-031 Reset asserted mid-transfer aborts the transfer; the pending write is not committed and no ACK cycle occurs.
REQ-032 After reset deassertion, the first tick occurs PRESCALE cycles later.

Verification
REQ-033 Write 0x1 to 0x0000, byte_en=4'b0001 -> busy low exactly 1 cycle after acceptance; soft_int=1 the cycle after ACK; read of 0x0000 returns 0x1.
REQ-034 PRESCALE=4, no bus traffic for 40 cycles after reset -> mtime reads 10 (±1 per the read's acceptance cycle).
REQ-035 Write mtimecmp hi=0, then lo=5, with PRESCALE=1 -> timer_int rises exactly one cycle after mtime becomes 5; then write mtimecmp lo=0xFFFF_FFFF -> timer_int falls one cycle after the commit.
REQ-036 Write mtime lo=0xFFFF_FFFF and hi=0xFFFF_FFFF -> after 1 tick mtime = 0 (wrap); timer_int tracks the compare result.
REQ-037 Write 0xAABBCCDD to 0x4000 with byte_en=4'b0100 -> mtimecmp[31:0] = 0xFFBBFFFF; read of 0x1234 returns 0; write to 0x1234 changes no register.
REQ-038 Issue a write to 0x0000, assert nRST in the acceptance cycle -> msip stays 0, busy = 1, and all registers hold their reset values.

Source files
------------

// File: rtl/clint_lite.sv
// Lightweight core-local interruptor: msip, mtime and mtimecmp behind a
// simple two-state generic-bus slave, plus a prescaled 64-bit timer.
module clint_lite #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        ren,
  input  logic        wen,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        timer_int,
  output logic        soft_int
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 16;
  localparam int unsigned TW = 64;

  localparam logic [15:0] OFF_MSIP    = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO  = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI  = 16'h4004;
  localparam logic [15:0] OFF_TIME_LO = 16'hBFF8;
  localparam logic [15:0] OFF_TIME_HI = 16'hBFFC;

  localparam logic [PW-1:0] PRESCALE_MAX = PW'(PRESCALE - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;

  logic [0:0]    state;
  logic [0:0]    state_next;
  logic          accept;

  logic          req_hit;
  logic [15:0]   req_off;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          req_write;

  logic [PW-1:0] presc;
  logic          tick;
  logic [TW-1:0] mtime;
  logic [TW-1:0] mtimecmp;
  logic          msip;

  logic          addr_hit;
  logic [DW-1:0] rd_val;
  logic          commit;

  // Replace only the byte lanes selected by be.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_val,
                                          input logic [DW-1:0] new_val,
                                          input logic [3:0]    be);
    logic [DW-1:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  assign addr_hit = (addr[31:16] == BASE_ADDR[31:16]);
  assign tick     = (presc == PRESCALE_MAX);
  assign commit   = (state == ACK) && req_write && req_hit;
  assign soft_int = msip;

  // Bus FSM next state: accept in IDLE, always leave ACK after one cycle.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (ren || wen) begin
          state_next = ACK;
          accept     = 1'b1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read mux over the live address, sampled in the acceptance cycle.
  always_comb begin
    rd_val = '0;
    if (addr_hit) begin
      case (addr[15:0])
        OFF_MSIP:    rd_val = {31'b0, msip};
        OFF_CMP_LO:  rd_val = mtimecmp[31:0];
        OFF_CMP_HI:  rd_val = mtimecmp[63:32];
        OFF_TIME_LO: rd_val = mtime[31:0];
        OFF_TIME_HI: rd_val = mtime[63:32];
        default:     rd_val = '0;
      endcase
    end
  end

  // Bus state, request latch, read data and wait signal.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state     <= IDLE;
      req_hit   <= 1'b0;
      req_off   <= '0;
      req_wdata <= '0;
      req_be    <= '0;
      req_write <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b1;
    end else begin
      state <= state_next;
      busy  <= (state_next != ACK);
      if (accept) begin
        req_hit   <= addr_hit;
        req_off   <= addr[15:0];
        req_wdata <= wdata;
        req_be    <= byte_en;
        req_write <= wen;
        rdata     <= wen ? '0 : rd_val;
      end
    end
  end

  // Prescaler: free-running, unaffected by mtime writes.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) presc <= '0;
    else      presc <= tick ? '0 : presc + PW'(1);
  end

  // mtime: a committed write suppresses that cycle's increment.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      mtime <= '0;
    end else if (commit && (req_off == OFF_TIME_LO)) begin
      mtime[31:0] <= merge(mtime[31:0], req_wdata, req_be);
    end else if (commit && (req_off == OFF_TIME_HI)) begin
      mtime[63:32] <= merge(mtime[63:32], req_wdata, req_be);
    end else if (tick) begin
      mtime <= mtime + TW'(1);
    end
  end

  // mtimecmp and msip software-writable registers.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else if (commit) begin
      case (req_off)
        OFF_CMP_LO: mtimecmp[31:0]  <= merge(mtimecmp[31:0], req_wdata, req_be);
        OFF_CMP_HI: mtimecmp[63:32] <= merge(mtimecmp[63:32], req_wdata, req_be);
        OFF_MSIP:   if (req_be[0]) msip <= req_wdata[0];
        default:    ;
      endcase
    end
  end

  // Timer interrupt reflects the previous cycle's compare.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) timer_int <= 1'b0;
    else      timer_int <= (mtime >= mtimecmp);
  end

endmodule

// File: tb/tb_clint_lite.sv
// Directed bench for clint_lite: two instances (PRESCALE 1 and 4) share one bus.
module tb_clint_lite;

  localparam logic [31:0] B = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic        ren, wen;
  logic [3:0]  byte_en;
  logic [31:0] rdata1, rdata4;
  logic        busy1, busy4, ti1, ti4, si1, si4;

  int n_checks = 0;
  int n_pass   = 0;
  logic ack_busy, ack_ti, ack_si;
  logic [31:0] v1, v4;

  always #5 clk = ~clk;

  clint_lite #(.BASE_ADDR(B), .PRESCALE(1)) dut1 (
    .CLK(clk), .nRST(rst), .addr(addr), .wdata(wdata), .ren(ren), .wen(wen),
    .byte_en(byte_en), .rdata(rdata1), .busy(busy1), .timer_int(ti1), .soft_int(si1)
  );

  clint_lite #(.BASE_ADDR(B), .PRESCALE(4)) dut4 (
    .CLK(clk), .nRST(rst), .addr(addr), .wdata(wdata), .ren(ren), .wen(wen),
    .byte_en(byte_en), .rdata(rdata4), .busy(busy4), .timer_int(ti4), .soft_int(si4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One transfer starting in an IDLE cycle; returns in the cycle after ACK.
  task automatic xfer(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      output logic [31:0] r1, output logic [31:0] r4);
    addr = a; wdata = d; byte_en = be; ren = r; wen = w;
    @(posedge clk); #1;
    ack_busy = busy1; ack_ti = ti1; ack_si = si1;
    r1 = rdata1; r4 = rdata4;
    ren = 1'b0; wen = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r1, output logic [31:0] r4);
    xfer(1'b1, 1'b0, a, 32'h0, 4'h0, r1, r4);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] d1, d4;
    xfer(1'b0, 1'b1, a, d, be, d1, d4);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; ren = 1'b0; wen = 1'b0; byte_en = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy1), 32'd1);
    check("rst_ti", 32'(ti1), 32'd0);
    check("rst_si", 32'(si1), 32'd0);
    check("rst_rdata", rdata1, 32'd0);
    rst = 1'b0;

    // Idle 40 cycles, then read mtime
    cyc(40);
    rd(B + 32'hBFF8, v1, v4);
    check("mtime_lo_p1", v1, 32'd40);
    check("mtime_lo_p4", v4, 32'd10);
    rd(B + 32'hBFFC, v1, v4);
    check("mtime_hi", v1, 32'd0);
    rd(B + 32'h4000, v1, v4);
    check("cmp_lo_rst", v1, 32'hFFFF_FFFF);
    rd(B + 32'h4004, v1, v4);
    check("cmp_hi_rst", v1, 32'hFFFF_FFFF);
    rd(B, v1, v4);
    check("msip_rst", v1, 32'd0);

    // msip write, handshake and soft interrupt
    wr(B, 32'h1, 4'b0001);
    check("msip_ack_busy", 32'(ack_busy), 32'd0);
    check("msip_si_in_ack", 32'(ack_si), 32'd0);
    check("msip_busy_after", 32'(busy1), 32'd1);
    check("msip_si_after", 32'(si1), 32'd1);
    rd(B, v1, v4);
    check("msip_rd", v1, 32'd1);
    xfer(1'b1, 1'b1, B, 32'h0, 4'b0001, v1, v4);
    check("rw_rdata", v1, 32'd0);
    check("rw_si", 32'(si1), 32'd0);
    wr(B, 32'h1, 4'b1110);
    check("msip_lane_off", 32'(si1), 32'd0);

    // Timer compare rising and falling edges (PRESCALE 1)
    wr(B + 32'hBFF8, 32'h0, 4'hF);
    wr(B + 32'h4004, 32'h0, 4'hF);
    wr(B + 32'h4000, 32'd5, 4'hF);
    check("ti_pre", 32'(ti1), 32'd0);
    cyc(1);
    check("ti_at_mtime5", 32'(ti1), 32'd0);
    cyc(1);
    check("ti_rise", 32'(ti1), 32'd1);
    wr(B + 32'h4000, 32'hFFFF_FFFF, 4'hF);
    check("ti_hold", 32'(ti1), 32'd1);
    cyc(1);
    check("ti_fall", 32'(ti1), 32'd0);

    // mtime write vs tick, then 64-bit wrap
    wr(B + 32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    rd(B + 32'hBFF8, v1, v4);
    check("mtime_wr_no_inc", v1, 32'd10);
    wr(B + 32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    rd(B + 32'hBFF8, v1, v4);
    check("mtime_all_ones", v1, 32'hFFFF_FFFF);
    check("ti_all_ones", 32'(ack_ti), 32'd1);
    check("ti_after_wrap", 32'(ti1), 32'd0);
    rd(B + 32'hBFFC, v1, v4);
    check("mtime_hi_wrap", v1, 32'd0);
    rd(B + 32'hBFF8, v1, v4);
    check("mtime_lo_wrap", v1, 32'd3);

    // Byte-lane write and unmapped addresses
    wr(B + 32'h4000, 32'hAABB_CCDD, 4'b0100);
    rd(B + 32'h4000, v1, v4);
    check("cmp_lo_lane2", v1, 32'hFFBB_FFFF);
    rd(B + 32'h1234, v1, v4);
    check("unmapped_rd", v1, 32'd0);
    wr(B + 32'h1234, 32'hFFFF_FFFF, 4'hF);
    rd(B, v1, v4);
    check("unmapped_msip", v1, 32'd0);
    rd(B + 32'h4000, v1, v4);
    check("unmapped_cmp_lo", v1, 32'hFFBB_FFFF);
    rd(B + 32'h4004, v1, v4);
    check("unmapped_cmp_hi", v1, 32'd0);
    wr(B, 32'h1, 4'b0001);
    rd(32'h0300_0000, v1, v4);
    check("outside_rd", v1, 32'd0);
    wr(32'h0300_0000, 32'h0, 4'hF);
    check("outside_wr_si", 32'(si1), 32'd1);

    // Reset during the acceptance cycle of a write
    addr = B; wdata = 32'h1; byte_en = 4'b0001; wen = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy1), 32'd1);
    check("midrst_si", 32'(si1), 32'd0);
    @(posedge clk); #1;
    wen = 1'b0;
    @(posedge clk); #1;
    check("midrst_no_ack", 32'(busy1), 32'd1);
    rst = 1'b0;
    check("postrst_si", 32'(si1), 32'd0);
    cyc(3);
    rd(B + 32'hBFF8, v1, v4);
    check("first_tick_p1", v1, 32'd3);
    check("first_tick_p4", v4, 32'd0);
    rd(B + 32'hBFF8, v1, v4);
    check("second_rd_p1", v1, 32'd5);
    check("second_rd_p4", v4, 32'd1);
    rd(B, v1, v4);
    check("postrst_msip", v1, 32'd0);
    rd(B + 32'h4000, v1, v4);
    check("postrst_cmp_lo", v1, 32'hFFFF_FFFF);
    rd(B + 32'h4004, v1, v4);
    check("postrst_cmp_hi", v1, 32'hFFFF_FFFF);
    check("postrst_ti", 32'(ti1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
